// File: rtl/xillybus_mem_pkg.sv
// Shared types and constants for the Xillybus seekable memory port.
// Holds the read-side FSM state type and the list of supported data widths.
package xillybus_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEEK  = 2'd1,
        ST_READY = 2'd2,
        ST_END   = 2'd3
    } rd_state_e;

    localparam int LEGAL_DW [3] = '{8, 16, 32};

    function automatic bit dw_is_legal(input int dw);
        return (dw == LEGAL_DW[0]) || (dw == LEGAL_DW[1]) || (dw == LEGAL_DW[2]);
    endfunction

endpackage

// File: rtl/xillybus_mem_ram.sv
// Simple dual-port RAM, DW x 2**AW, synchronous read-first read port.
// Only the read-data register is reset; the array contents survive reset.
module xillybus_mem_ram
    import xillybus_mem_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_d;
    logic [DW-1:0] rdata_q;

    // Array read happens before the same-edge write lands, giving read-first.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/xillybus_mem_port.sv
// Seekable memory behind a Xillybus write stream and read stream.
// Build option XILLYBUS_MEM_PORT_EOF_EN: reading the last word raises eof.
//
// state    | meaning
// ---------|---------------------------------------------------------
// ST_IDLE  | read file closed, or waiting for it to open
// ST_SEEK  | one-cycle hold after a seek, read side reports empty
// ST_READY | words available, rden accepted
// ST_END   | last address consumed, eof raised until the next seek
module xillybus_mem_port
    import xillybus_mem_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 5
) (
    input  logic          bus_clk,
    input  logic          bus_rst,
    input  logic          user_w_mem_wren,
    input  logic [DW-1:0] user_w_mem_data,
    output logic          user_w_mem_full,
    input  logic          user_w_mem_open,
    input  logic          user_r_mem_rden,
    output logic [DW-1:0] user_r_mem_data,
    output logic          user_r_mem_empty,
    output logic          user_r_mem_eof,
    input  logic          user_r_mem_open,
    input  logic [AW-1:0] user_mem_addr,
    input  logic          user_mem_addr_update
);

    if (!dw_is_legal(DW)) begin : g_bad_dw
        $error("xillybus_mem_port: DW must be 8, 16 or 32");
    end
    if (AW < 1 || AW > 16) begin : g_bad_aw
        $error("xillybus_mem_port: AW must be within 1..16");
    end

    // The write side never stalls on file state, so the open flag is informational.
    logic unused_w_open;
    assign unused_w_open = user_w_mem_open;

    rd_state_e     state_d, state_q;
    logic [AW-1:0] wptr_d, wptr_q;
    logic [AW-1:0] rptr_d, rptr_q;
    logic          full_d, full_q;
    logic          empty_d, empty_q;
    logic          r_open_d, r_open_q;
    logic          rd_accept;
    logic          ram_we;
    logic          ram_re;
`ifdef XILLYBUS_MEM_PORT_EOF_EN
    logic          eof_d, eof_q;
`endif

    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        rd_accept = user_r_mem_rden && !empty_q;

        // A seek overrides any increment owed by a coincident strobe.
        if (user_mem_addr_update) begin
            wptr_d = user_mem_addr;
            rptr_d = user_mem_addr;
        end else begin
            if (user_w_mem_wren) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (rd_accept) begin
                rptr_d = rptr_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (user_r_mem_open && !r_open_q) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (user_mem_addr_update) begin
                    state_d = ST_SEEK;
                end
`ifdef XILLYBUS_MEM_PORT_EOF_EN
                else if (rd_accept && (rptr_q == '1)) begin
                    state_d = ST_END;
                end
`endif
            end
            ST_SEEK: begin
                state_d = ST_READY;
            end
            ST_END: begin
                if (user_mem_addr_update) begin
                    state_d = ST_SEEK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!user_r_mem_open) begin
            state_d = ST_IDLE;
        end

        full_d   = user_mem_addr_update;
        empty_d  = (state_d != ST_READY);
        r_open_d = user_r_mem_open;
`ifdef XILLYBUS_MEM_PORT_EOF_EN
        eof_d    = (state_d == ST_END);
`endif
    end

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            state_q  <= ST_IDLE;
            wptr_q   <= '0;
            rptr_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            r_open_q <= 1'b0;
`ifdef XILLYBUS_MEM_PORT_EOF_EN
            eof_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            r_open_q <= r_open_d;
`ifdef XILLYBUS_MEM_PORT_EOF_EN
            eof_q    <= eof_d;
`endif
        end
    end

    // Reset also blocks RAM traffic so a read in flight is dropped.
    assign ram_we = user_w_mem_wren && !bus_rst;
    assign ram_re = rd_accept && !bus_rst;

    xillybus_mem_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk   (bus_clk),
        .rst   (bus_rst),
        .we    (ram_we),
        .waddr (wptr_q),
        .wdata (user_w_mem_data),
        .re    (ram_re),
        .raddr (rptr_q),
        .rdata (user_r_mem_data)
    );

    assign user_w_mem_full  = full_q;
    assign user_r_mem_empty = empty_q;
`ifdef XILLYBUS_MEM_PORT_EOF_EN
    assign user_r_mem_eof   = eof_q;
`else
    assign user_r_mem_eof   = 1'b0;
`endif

endmodule

// File: tb/tb_xillybus_mem_port.sv
// Bench for xillybus_mem_port (DW=32, AW=5): directed scenarios followed by
// random traffic, all compared against a word-level reference model.
module tb_xillybus_mem_port;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
`ifdef XILLYBUS_MEM_PORT_EOF_EN
    localparam bit EOF_ON = 1'b1;
`else
    localparam bit EOF_ON = 1'b0;
`endif

    logic          bus_clk = 1'b0;
    logic          bus_rst = 1'b1;
    logic          user_w_mem_wren = 1'b0;
    logic [DW-1:0] user_w_mem_data = '0;
    logic          user_w_mem_full;
    logic          user_w_mem_open = 1'b1;
    logic          user_r_mem_rden = 1'b0;
    logic [DW-1:0] user_r_mem_data;
    logic          user_r_mem_empty;
    logic          user_r_mem_eof;
    logic          user_r_mem_open = 1'b0;
    logic [AW-1:0] user_mem_addr = '0;
    logic          user_mem_addr_update = 1'b0;

    always #5 bus_clk = ~bus_clk;

    xillybus_mem_port #(.DW(DW), .AW(AW)) dut (
        .bus_clk              (bus_clk),
        .bus_rst              (bus_rst),
        .user_w_mem_wren      (user_w_mem_wren),
        .user_w_mem_data      (user_w_mem_data),
        .user_w_mem_full      (user_w_mem_full),
        .user_w_mem_open      (user_w_mem_open),
        .user_r_mem_rden      (user_r_mem_rden),
        .user_r_mem_data      (user_r_mem_data),
        .user_r_mem_empty     (user_r_mem_empty),
        .user_r_mem_eof       (user_r_mem_eof),
        .user_r_mem_open      (user_r_mem_open),
        .user_mem_addr        (user_mem_addr),
        .user_mem_addr_update (user_mem_addr_update)
    );

    // Reference model: a word array, two integer pointers and a read mode.
    typedef enum int {M_CLOSED, M_SEEKING, M_OPEN, M_AT_END} mode_t;
    logic [31:0] m_mem [DEPTH];
    int          m_wp = 0;
    int          m_rp = 0;
    logic [31:0] m_data = '0;
    mode_t       m_mode = M_CLOSED;
    bit          m_full = 1'b0;
    bit          m_prev_open = 1'b0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit acc;
        bit hit;
        if (bus_rst) begin
            m_wp = 0; m_rp = 0; m_data = '0;
            m_mode = M_CLOSED; m_full = 1'b0; m_prev_open = 1'b0;
            return;
        end
        acc = user_r_mem_rden && (m_mode == M_OPEN);
        hit = acc && EOF_ON && (m_rp == DEPTH - 1);
        if (acc) m_data = m_mem[m_rp];
        if (user_w_mem_wren) m_mem[m_wp] = user_w_mem_data;
        if (user_mem_addr_update) begin
            m_wp = int'(user_mem_addr);
            m_rp = int'(user_mem_addr);
        end else begin
            if (user_w_mem_wren) m_wp = (m_wp + 1) % DEPTH;
            if (acc) m_rp = (m_rp + 1) % DEPTH;
        end
        m_full = user_mem_addr_update;
        if (!user_r_mem_open) begin
            m_mode = M_CLOSED;
        end else begin
            case (m_mode)
                M_CLOSED:  if (!m_prev_open) m_mode = M_OPEN;
                M_OPEN:    if (user_mem_addr_update) m_mode = M_SEEKING;
                           else if (hit) m_mode = M_AT_END;
                M_SEEKING: m_mode = M_OPEN;
                M_AT_END:  if (user_mem_addr_update) m_mode = M_SEEKING;
                default:   m_mode = M_CLOSED;
            endcase
        end
        m_prev_open = user_r_mem_open;
    endtask

    task automatic tick();
        @(posedge bus_clk);
        model_step();
        #1;
        chk("empty", {31'd0, user_r_mem_empty}, {31'd0, m_mode != M_OPEN});
        chk("eof",   {31'd0, user_r_mem_eof},   {31'd0, m_mode == M_AT_END});
        chk("full",  {31'd0, user_w_mem_full},  {31'd0, m_full});
        chk("data",  user_r_mem_data, m_data);
    endtask

    task automatic step(input bit wr, input logic [31:0] wd, input bit rd,
                        input bit up, input logic [AW-1:0] ad);
        user_w_mem_wren      = wr;
        user_w_mem_data      = wd;
        user_r_mem_rden      = rd;
        user_mem_addr_update = up;
        user_mem_addr        = ad;
        tick();
        user_w_mem_wren      = 1'b0;
        user_r_mem_rden      = 1'b0;
        user_mem_addr_update = 1'b0;
    endtask

    initial begin
        logic [31:0] e_a, e_b, e_c;

        tick();
        tick();
        chk("rst_empty", {31'd0, user_r_mem_empty}, 32'd1);
        chk("rst_eof",   {31'd0, user_r_mem_eof},   32'd0);
        chk("rst_full",  {31'd0, user_w_mem_full},  32'd0);
        chk("rst_data",  user_r_mem_data, 32'd0);

        bus_rst = 1'b0;
        user_r_mem_open = 1'b1;
        tick();
        chk("open_ready", {31'd0, user_r_mem_empty}, 32'd0);

        // Give every word a known value.
        step(0, 0, 0, 1, 5'd0);
        chk("seek_full", {31'd0, user_w_mem_full}, 32'd1);
        for (int i = 0; i < DEPTH; i++) step(1, $urandom, 0, 0, 5'd0);

        // Seek, write two words, seek back, read them back.
        step(0, 0, 0, 1, 5'd3);
        step(1, 32'h0000_00A1, 0, 0, 5'd0);
        step(1, 32'h0000_00B2, 0, 0, 5'd0);
        step(0, 0, 0, 1, 5'd3);
        step(0, 0, 0, 0, 5'd0);
        step(0, 0, 1, 0, 5'd0);
        chk("rd_a1", user_r_mem_data, 32'h0000_00A1);
        step(0, 0, 1, 0, 5'd0);
        chk("rd_b2", user_r_mem_data, 32'h0000_00B2);

        // Last address: wrap without eof, or end-of-file with it.
        e_a = m_mem[31]; e_b = m_mem[0]; e_c = m_mem[1];
        step(0, 0, 0, 1, 5'd31);
        step(0, 0, 0, 0, 5'd0);
        step(0, 0, 1, 0, 5'd0);
        chk("rd_31", user_r_mem_data, e_a);
        if (EOF_ON) begin
            chk("end_eof",   {31'd0, user_r_mem_eof},   32'd1);
            chk("end_empty", {31'd0, user_r_mem_empty}, 32'd1);
            step(0, 0, 0, 1, 5'd0);
            chk("seek_eof",  {31'd0, user_r_mem_eof},   32'd0);
            step(0, 0, 0, 0, 5'd0);
            chk("reseek_empty", {31'd0, user_r_mem_empty}, 32'd0);
        end else begin
            step(0, 0, 1, 0, 5'd0);
            chk("wrap_0", user_r_mem_data, e_b);
            step(0, 0, 1, 0, 5'd0);
            chk("wrap_1", user_r_mem_data, e_c);
            chk("wrap_eof", {31'd0, user_r_mem_eof}, 32'd0);
        end

        // Same-cycle read and write to one address returns the old word.
        step(0, 0, 0, 1, 5'd7);
        step(1, 32'h1111_1111, 0, 0, 5'd0);
        step(0, 0, 0, 1, 5'd7);
        step(0, 0, 0, 0, 5'd0);
        step(1, 32'h2222_2222, 1, 0, 5'd0);
        chk("rf_old", user_r_mem_data, 32'h1111_1111);
        step(0, 0, 0, 1, 5'd7);
        step(0, 0, 0, 0, 5'd0);
        step(0, 0, 1, 0, 5'd0);
        chk("rf_new", user_r_mem_data, 32'h2222_2222);

        // Seek coinciding with a read.
        step(0, 0, 0, 1, 5'd4);
        step(0, 0, 0, 0, 5'd0);
        e_a = m_mem[4]; e_b = m_mem[10];
        step(0, 0, 1, 1, 5'd10);
        chk("sk_rd_data",  user_r_mem_data, e_a);
        chk("sk_rd_empty", {31'd0, user_r_mem_empty}, 32'd1);
        step(0, 0, 0, 0, 5'd0);
        chk("sk_ready", {31'd0, user_r_mem_empty}, 32'd0);
        step(0, 0, 1, 0, 5'd0);
        chk("sk_rd_10", user_r_mem_data, e_b);

        // Reset in the middle of back-to-back reads.
        step(0, 0, 0, 1, 5'd5);
        step(0, 0, 0, 0, 5'd0);
        e_a = m_mem[0];
        user_r_mem_rden = 1'b1;
        tick();
        bus_rst = 1'b1;
        tick();
        bus_rst = 1'b0;
        chk("mid_rst_empty", {31'd0, user_r_mem_empty}, 32'd1);
        chk("mid_rst_eof",   {31'd0, user_r_mem_eof},   32'd0);
        chk("mid_rst_data",  user_r_mem_data, 32'd0);
        tick();
        tick();
        chk("post_rst_rd0", user_r_mem_data, e_a);
        user_r_mem_rden = 1'b0;

        // Close and reopen the read file.
        user_r_mem_open = 1'b0;
        tick();
        chk("closed_empty", {31'd0, user_r_mem_empty}, 32'd1);
        step(0, 0, 1, 0, 5'd0);
        user_r_mem_open = 1'b1;
        tick();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) bus_rst = 1'b1;
            if ($urandom_range(0, 49) == 0) user_r_mem_open = ~user_r_mem_open;
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 11) == 0), 5'($urandom_range(0, DEPTH - 1)));
            bus_rst = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
